// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths, default queue depth and queue entry type for the
// register-file write arbiter and its deferred-result queue.
package rf_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int QDEPTH_DEF = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        data_t     data;
    } wq_entry_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle between pipeline/md unit/decode (master) and the arbiter (slave).
// Ports: wb write request, md result + mdReady, rs/rt + rawStall, RF write port.
interface rf_write_arbiter_if;
    import rf_write_arbiter_pkg::*;

    logic      wbRegWrite;
    reg_addr_t wbRd;
    data_t     wbData;
    logic      mdValid;
    reg_addr_t mdRd;
    data_t     mdData;
    logic      mdReady;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      rawStall;
    logic      regWrite;
    reg_addr_t rd;
    data_t     writeData;

    modport master (
        output wbRegWrite, wbRd, wbData,
        output mdValid, mdRd, mdData,
        output rs, rt,
        input  mdReady, rawStall,
        input  regWrite, rd, writeData
    );

    modport slave (
        input  wbRegWrite, wbRd, wbData,
        input  mdValid, mdRd, mdData,
        input  rs, rt,
        output mdReady, rawStall,
        output regWrite, rd, writeData
    );

endinterface

// File: rtl/rf_wb_queue.sv
// Compacting FIFO of deferred md results with pop, rd-match squash and
// per-entry rs/rt match vectors. Ports: push/pop/squash in, head/count/hits out.
module rf_wb_queue
    import rf_write_arbiter_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF,
    localparam int CW = $clog2(QDEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  reg_addr_t         push_rd,
    input  data_t             push_data,
    input  logic              pop,
    input  logic              squash,
    input  reg_addr_t         squash_rd,
    input  reg_addr_t         rs,
    input  reg_addr_t         rt,
    output logic              head_valid,
    output reg_addr_t         head_rd,
    output data_t             head_data,
    output logic [CW-1:0]     count,
    output logic [QDEPTH-1:0] rs_hit,
    output logic [QDEPTH-1:0] rt_hit
);

    wq_entry_t         q     [QDEPTH];
    wq_entry_t         q_nxt [QDEPTH];
    logic [QDEPTH-1:0] keep;
    logic [CW-1:0]     cnt_nxt;
    int                k;

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            keep[i] = q[i].valid
                   && !(pop && i == 0)
                   && !(squash && q[i].rd == squash_rd);
        end
    end

    // Survivors slide toward the head in order; a push lands after them.
    always_comb begin
        k = 0;
        for (int j = 0; j < QDEPTH; j++) begin
            q_nxt[j] = '0;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (keep[i]) begin
                for (int j = 0; j < QDEPTH; j++) begin
                    if (j == k) q_nxt[j] = q[i];
                end
                k = k + 1;
            end
        end
        if (push && k < QDEPTH) begin
            for (int j = 0; j < QDEPTH; j++) begin
                if (j == k) begin
                    q_nxt[j] = '{valid: 1'b1, rd: push_rd, data: push_data};
                end
            end
            k = k + 1;
        end
        cnt_nxt = CW'(k);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q[i] <= '0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                q[i] <= q_nxt[i];
            end
            count <= cnt_nxt;
        end
    end

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            rs_hit[i] = q[i].valid && q[i].rd == rs;
            rt_hit[i] = q[i].valid && q[i].rd == rt;
        end
    end

    assign head_valid = q[0].valid;
    assign head_rd    = q[0].rd;
    assign head_data  = q[0].data;

endmodule

// File: rtl/rf_write_arbiter.sv
// Merges pipeline writeback and mult/div results onto one RF write port.
// Ports: clk, reset, bus (slave): wb/md requests, mdReady, rawStall, RF port.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF
) (
    input logic               clk,
    input logic               reset,
    rf_write_arbiter_if.slave bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic              head_valid;
    reg_addr_t         head_rd;
    data_t             head_data;
    logic [CW-1:0]     count;
    logic [QDEPTH-1:0] rs_hit;
    logic [QDEPTH-1:0] rt_hit;

    logic wb_act;
    logic md_ready;
    logic md_acc;
    logic md_pend;
    logic sel_wb;
    logic sel_q;
    logic sel_md;
    logic push;
    logic rs_stall;
    logic rt_stall;

    assign wb_act   = bus.wbRegWrite && bus.wbRd != '0;
    assign md_ready = !reset && count < CW'(QDEPTH);
    assign md_acc   = bus.mdValid && md_ready;
    assign md_pend  = bus.mdValid && !md_acc;

    assign sel_wb = !reset && wb_act;
    assign sel_q  = !reset && !wb_act && head_valid;
    assign sel_md = !reset && !wb_act && !head_valid
                 && md_acc && bus.mdRd != '0;

    // rd 0 results vanish; an md result to the same rd as an active wb
    // write is the older value and is dropped.
    assign push = md_acc && !sel_md && bus.mdRd != '0
               && !(wb_act && bus.mdRd == bus.wbRd);

    rf_wb_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_rd    (bus.mdRd),
        .push_data  (bus.mdData),
        .pop        (sel_q),
        .squash     (sel_wb),
        .squash_rd  (bus.wbRd),
        .rs         (bus.rs),
        .rt         (bus.rt),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .count      (count),
        .rs_hit     (rs_hit),
        .rt_hit     (rt_hit)
    );

    always_comb begin
        bus.regWrite  = 1'b0;
        bus.rd        = '0;
        bus.writeData = '0;
        unique case (1'b1)
            sel_wb: begin
                bus.regWrite  = 1'b1;
                bus.rd        = bus.wbRd;
                bus.writeData = bus.wbData;
            end
            sel_q: begin
                bus.regWrite  = 1'b1;
                bus.rd        = head_rd;
                bus.writeData = head_data;
            end
            sel_md: begin
                bus.regWrite  = 1'b1;
                bus.rd        = bus.mdRd;
                bus.writeData = bus.mdData;
            end
            default: ;
        endcase
    end

    assign rs_stall = bus.rs != '0
                   && (|rs_hit || (md_pend && bus.rs == bus.mdRd));
    assign rt_stall = bus.rt != '0
                   && (|rt_hit || (md_pend && bus.rt == bus.mdRd));

    assign bus.mdReady  = md_ready;
    assign bus.rawStall = !reset && (rs_stall || rt_stall);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (QDEPTH=2) with a small RF sink.
// Inputs driven on negedge, outputs sampled 1ns later.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;

    logic [31:0] rf [32];
    int          wr_cnt [32];

    always #5 clk = ~clk;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .QDEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.regWrite) begin
            rf[bus.rd]     <= bus.writeData;
            wr_cnt[bus.rd] <= wr_cnt[bus.rd] + 1;
        end
    end

    task automatic idle();
        bus.wbRegWrite = 1'b0;
        bus.wbRd       = '0;
        bus.wbData     = '0;
        bus.mdValid    = 1'b0;
        bus.mdRd       = '0;
        bus.mdData     = '0;
        bus.rs         = '0;
        bus.rt         = '0;
    endtask

    task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        bus.wbRegWrite = en;
        bus.wbRd       = r;
        bus.wbData     = d;
    endtask

    task automatic md(input logic v, input logic [4:0] r, input logic [31:0] d);
        bus.mdValid = v;
        bus.mdRd    = r;
        bus.mdData  = d;
    endtask

    task automatic test_reset();
        @(negedge clk);
        wb(1'b1, 5'd1, 32'h9);
        md(1'b1, 5'd3, 32'h55);
        bus.rs = 5'd3;
        #1;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL rst_we got=%0h exp=0", bus.regWrite); else n_pass++;
        n_total++; if (bus.rd !== 5'd0) $display("FAIL rst_rd got=%0h exp=0", bus.rd); else n_pass++;
        n_total++; if (bus.writeData !== 32'h0) $display("FAIL rst_wd got=%0h exp=0", bus.writeData); else n_pass++;
        n_total++; if (bus.mdReady !== 1'b0) $display("FAIL rst_rdy got=%0h exp=0", bus.mdReady); else n_pass++;
        n_total++; if (bus.rawStall !== 1'b0) $display("FAIL rst_stall got=%0h exp=0", bus.rawStall); else n_pass++;
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        n_total++; if (bus.mdReady !== 1'b1) $display("FAIL rel_rdy got=%0h exp=1", bus.mdReady); else n_pass++;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL rel_we got=%0h exp=0", bus.regWrite); else n_pass++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        md(1'b1, 5'd3, 32'h55);
        #1;
        n_total++; if (bus.regWrite !== 1'b1) $display("FAIL byp_we got=%0h exp=1", bus.regWrite); else n_pass++;
        n_total++; if (bus.rd !== 5'd3) $display("FAIL byp_rd got=%0h exp=3", bus.rd); else n_pass++;
        n_total++; if (bus.writeData !== 32'h55) $display("FAIL byp_wd got=%0h exp=55", bus.writeData); else n_pass++;
        n_total++; if (bus.mdReady !== 1'b1) $display("FAIL byp_rdy got=%0h exp=1", bus.mdReady); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL byp_empty got=%0h exp=0", bus.regWrite); else n_pass++;
        n_total++; if (rf[3] !== 32'h55) $display("FAIL byp_rf3 got=%0h exp=55", rf[3]); else n_pass++;
    endtask

    task automatic test_collision();
        @(negedge clk);
        wb(1'b1, 5'd1, 32'h9);
        md(1'b1, 5'd2, 32'h7);
        #1;
        n_total++; if (bus.rd !== 5'd1 || bus.writeData !== 32'h9) $display("FAIL col_wb got=%0h/%0h exp=1/9", bus.rd, bus.writeData); else n_pass++;
        n_total++; if (bus.mdReady !== 1'b1) $display("FAIL col_rdy got=%0h exp=1", bus.mdReady); else n_pass++;
        @(negedge clk);
        idle();
        bus.rs = 5'd2;
        #1;
        n_total++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd2 || bus.writeData !== 32'h7) $display("FAIL col_q got=%0h/%0h/%0h exp=1/2/7", bus.regWrite, bus.rd, bus.writeData); else n_pass++;
        n_total++; if (bus.rawStall !== 1'b1) $display("FAIL col_stall got=%0h exp=1", bus.rawStall); else n_pass++;
        @(negedge clk);
        bus.rs = 5'd2;
        #1;
        n_total++; if (bus.rawStall !== 1'b0) $display("FAIL col_nostall got=%0h exp=0", bus.rawStall); else n_pass++;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL col_done got=%0h exp=0", bus.regWrite); else n_pass++;
        n_total++; if (rf[1] !== 32'h9 || rf[2] !== 32'h7) $display("FAIL col_rf got=%0h/%0h exp=9/7", rf[1], rf[2]); else n_pass++;
        idle();
    endtask

    task automatic test_full();
        @(negedge clk);
        wb(1'b1, 5'd10, 32'hA0);
        md(1'b1, 5'd5, 32'h500);
        #1;
        n_total++; if (bus.mdReady !== 1'b1) $display("FAIL full_rdy0 got=%0h exp=1", bus.mdReady); else n_pass++;
        @(negedge clk);
        md(1'b1, 5'd6, 32'h600);
        #1;
        n_total++; if (bus.mdReady !== 1'b1) $display("FAIL full_rdy1 got=%0h exp=1", bus.mdReady); else n_pass++;
        @(negedge clk);
        md(1'b1, 5'd7, 32'h700);
        bus.rs = 5'd7;
        #1;
        n_total++; if (bus.mdReady !== 1'b0) $display("FAIL full_rdy2 got=%0h exp=0", bus.mdReady); else n_pass++;
        n_total++; if (bus.rawStall !== 1'b1) $display("FAIL full_stall_md got=%0h exp=1", bus.rawStall); else n_pass++;
        @(negedge clk);
        wb(1'b0, 5'd0, 32'h0);
        bus.rs = 5'd0;
        bus.rt = 5'd6;
        #1;
        n_total++; if (bus.rd !== 5'd5 || bus.writeData !== 32'h500) $display("FAIL full_drain5 got=%0h/%0h exp=5/500", bus.rd, bus.writeData); else n_pass++;
        n_total++; if (bus.mdReady !== 1'b0) $display("FAIL full_rdy_pop got=%0h exp=0", bus.mdReady); else n_pass++;
        n_total++; if (bus.rawStall !== 1'b1) $display("FAIL full_stall_q got=%0h exp=1", bus.rawStall); else n_pass++;
        @(negedge clk);
        bus.rt = 5'd0;
        #1;
        n_total++; if (bus.rd !== 5'd6 || bus.writeData !== 32'h600) $display("FAIL full_drain6 got=%0h/%0h exp=6/600", bus.rd, bus.writeData); else n_pass++;
        n_total++; if (bus.mdReady !== 1'b1) $display("FAIL full_rdy3 got=%0h exp=1", bus.mdReady); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_total++; if (bus.regWrite !== 1'b1 || bus.rd !== 5'd7 || bus.writeData !== 32'h700) $display("FAIL full_drain7 got=%0h/%0h/%0h exp=1/7/700", bus.regWrite, bus.rd, bus.writeData); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL full_empty got=%0h exp=0", bus.regWrite); else n_pass++;
    endtask

    task automatic test_squash();
        int c4;
        c4 = wr_cnt[4];
        @(negedge clk);
        wb(1'b1, 5'd1, 32'h33);
        md(1'b1, 5'd4, 32'h11);
        @(negedge clk);
        wb(1'b1, 5'd4, 32'h22);
        md(1'b0, 5'd0, 32'h0);
        #1;
        n_total++; if (bus.rd !== 5'd4 || bus.writeData !== 32'h22) $display("FAIL sq_wb got=%0h/%0h exp=4/22", bus.rd, bus.writeData); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL sq_gone got=%0h exp=0", bus.regWrite); else n_pass++;
        @(negedge clk);
        n_total++; if (rf[4] !== 32'h22) $display("FAIL sq_rf4 got=%0h exp=22", rf[4]); else n_pass++;
        n_total++; if (wr_cnt[4] - c4 !== 1) $display("FAIL sq_cnt4 got=%0d exp=1", wr_cnt[4] - c4); else n_pass++;
        // md result older than a same-cycle wb to the same register
        wb(1'b1, 5'd8, 32'h80);
        md(1'b1, 5'd8, 32'h81);
        #1;
        n_total++; if (bus.mdReady !== 1'b1 || bus.writeData !== 32'h80) $display("FAIL waw_wb got=%0h/%0h exp=1/80", bus.mdReady, bus.writeData); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL waw_drop got=%0h exp=0", bus.regWrite); else n_pass++;
        n_total++; if (rf[8] !== 32'h80) $display("FAIL waw_rf8 got=%0h exp=80", rf[8]); else n_pass++;
    endtask

    task automatic test_zero();
        @(negedge clk);
        wb(1'b1, 5'd0, 32'hFF);
        md(1'b1, 5'd0, 32'hEE);
        #1;
        n_total++; if (bus.regWrite !== 1'b0 || bus.rd !== 5'd0) $display("FAIL z_we got=%0h/%0h exp=0/0", bus.regWrite, bus.rd); else n_pass++;
        n_total++; if (bus.mdReady !== 1'b1) $display("FAIL z_rdy got=%0h exp=1", bus.mdReady); else n_pass++;
        @(negedge clk);
        idle();
        #1;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL z_noq got=%0h exp=0", bus.regWrite); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wb(1'b1, 5'd11, 32'hB0);
        md(1'b1, 5'd12, 32'hC0);
        @(negedge clk);
        md(1'b1, 5'd13, 32'hD0);
        @(negedge clk);
        md(1'b0, 5'd0, 32'h0);
        bus.rs = 5'd12;
        #1;
        n_total++; if (bus.mdReady !== 1'b0) $display("FAIL rm_full got=%0h exp=0", bus.mdReady); else n_pass++;
        n_total++; if (bus.rawStall !== 1'b1) $display("FAIL rm_stall got=%0h exp=1", bus.rawStall); else n_pass++;
        #1;
        reset = 1'b1;
        #1;
        n_total++; if (bus.regWrite !== 1'b0 || bus.mdReady !== 1'b0) $display("FAIL rm_async got=%0h/%0h exp=0/0", bus.regWrite, bus.mdReady); else n_pass++;
        n_total++; if (bus.rawStall !== 1'b0) $display("FAIL rm_nostall got=%0h exp=0", bus.rawStall); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        n_total++; if (bus.regWrite !== 1'b0 || bus.mdReady !== 1'b1) $display("FAIL rm_rel got=%0h/%0h exp=0/1", bus.regWrite, bus.mdReady); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (bus.regWrite !== 1'b0) $display("FAIL rm_empty got=%0h exp=0", bus.regWrite); else n_pass++;
        n_total++; if (wr_cnt[12] !== 0 || wr_cnt[13] !== 0) $display("FAIL rm_lost got=%0d/%0d exp=0/0", wr_cnt[12], wr_cnt[13]); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]     = '0;
            wr_cnt[i] = 0;
        end
        reset = 1'b1;
        idle();
        test_reset();
        test_bypass();
        test_collision();
        test_full();
        test_squash();
        test_zero();
        test_reset_mid();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
